// File: rtl/beta_pkg.sv
// beta_pkg: shared definitions for the Beta core.
//   - Opcode constants for memory, control-transfer, OP and OPC groups.
//   - ALU function codes (low four opcode bits within the OP/OPC groups).
//   - alu_fn_valid(): true for function codes the ALU implements.
package beta_pkg;

    // Memory and control-transfer opcodes
    localparam logic [5:0] OPCODE_LD    = 6'h18;
    localparam logic [5:0] OPCODE_ST    = 6'h19;
    localparam logic [5:0] OPCODE_JMP   = 6'h1B;
    localparam logic [5:0] OPCODE_BEQ   = 6'h1C;
    localparam logic [5:0] OPCODE_BNE   = 6'h1D;
    localparam logic [5:0] OPCODE_LDR   = 6'h1F;

    // OP group: Rc <- Ra op Rb
    localparam logic [5:0] OPCODE_ADD   = 6'h20;
    localparam logic [5:0] OPCODE_SUB   = 6'h21;
    localparam logic [5:0] OPCODE_MUL   = 6'h22;
    localparam logic [5:0] OPCODE_DIV   = 6'h23;
    localparam logic [5:0] OPCODE_CMPEQ = 6'h24;
    localparam logic [5:0] OPCODE_CMPLT = 6'h25;
    localparam logic [5:0] OPCODE_CMPLE = 6'h26;
    localparam logic [5:0] OPCODE_AND   = 6'h28;
    localparam logic [5:0] OPCODE_OR    = 6'h29;
    localparam logic [5:0] OPCODE_XOR   = 6'h2A;
    localparam logic [5:0] OPCODE_XNOR  = 6'h2B;
    localparam logic [5:0] OPCODE_SHL   = 6'h2C;
    localparam logic [5:0] OPCODE_SHR   = 6'h2D;
    localparam logic [5:0] OPCODE_SRA   = 6'h2E;

    // OPC group: Rc <- Ra op SXT(lit)
    localparam logic [5:0] OPCODE_ADDC   = 6'h30;
    localparam logic [5:0] OPCODE_SUBC   = 6'h31;
    localparam logic [5:0] OPCODE_MULC   = 6'h32;
    localparam logic [5:0] OPCODE_DIVC   = 6'h33;
    localparam logic [5:0] OPCODE_CMPEQC = 6'h34;
    localparam logic [5:0] OPCODE_CMPLTC = 6'h35;
    localparam logic [5:0] OPCODE_CMPLEC = 6'h36;
    localparam logic [5:0] OPCODE_ANDC   = 6'h38;
    localparam logic [5:0] OPCODE_ORC    = 6'h39;
    localparam logic [5:0] OPCODE_XORC   = 6'h3A;
    localparam logic [5:0] OPCODE_XNORC  = 6'h3B;
    localparam logic [5:0] OPCODE_SHLC   = 6'h3C;
    localparam logic [5:0] OPCODE_SHRC   = 6'h3D;
    localparam logic [5:0] OPCODE_SRAC   = 6'h3E;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_MUL   = 4'h2,
        ALU_DIV   = 4'h3,
        ALU_CMPEQ = 4'h4,
        ALU_CMPLT = 4'h5,
        ALU_CMPLE = 4'h6,
        ALU_AND   = 4'h8,
        ALU_OR    = 4'h9,
        ALU_XOR   = 4'hA,
        ALU_XNOR  = 4'hB,
        ALU_SHL   = 4'hC,
        ALU_SHR   = 4'hD,
        ALU_SRA   = 4'hE
    } alu_fn_e;

    // Function codes 3, 7 and F have no ALU operation and decode as NOP.
    function automatic logic alu_fn_valid(input logic [3:0] fn);
        return !(fn == 4'h3 || fn == 4'h7 || fn == 4'hF);
    endfunction

endpackage

// File: rtl/beta_alu.sv
// beta_alu: combinational Beta ALU.
//   a_i, b_i  : operands (b_i is Rb or SXT(lit))
//   fn_i      : function code (opcode[3:0])
//   result_o  : result; compares give 0/1, shifts use b_i[4:0]
module beta_alu
    import beta_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  alu_fn_e     fn_i,
    output logic [31:0] result_o
);

    logic [31:0] prod;
    logic [4:0]  shamt;

    assign prod  = a_i * b_i;   // low 32 bits only
    assign shamt = b_i[4:0];

    always_comb begin
        result_o = '0;
        unique case (fn_i)
            ALU_ADD:   result_o = a_i + b_i;
            ALU_SUB:   result_o = a_i - b_i;
            ALU_MUL:   result_o = prod;
            ALU_CMPEQ: result_o = {31'b0, a_i == b_i};
            ALU_CMPLT: result_o = {31'b0, $signed(a_i) <  $signed(b_i)};
            ALU_CMPLE: result_o = {31'b0, $signed(a_i) <= $signed(b_i)};
            ALU_AND:   result_o = a_i & b_i;
            ALU_OR:    result_o = a_i | b_i;
            ALU_XOR:   result_o = a_i ^ b_i;
            ALU_XNOR:  result_o = ~(a_i ^ b_i);
            ALU_SHL:   result_o = a_i << shamt;
            ALU_SHR:   result_o = a_i >> shamt;
            ALU_SRA:   result_o = $unsigned($signed(a_i) >>> shamt);
            default:   result_o = '0;
        endcase
    end

endmodule

// File: rtl/beta_core.sv
// beta_core: single-cycle, non-pipelined Beta processor.
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   i_mem_r_addr  : instruction byte address (PC); RESET_PC while in reset
//   i_mem_r_data  : instruction word (combinational)
//   d_mem_w_addr  : data byte address for LD/LDR/ST, 0 otherwise
//   d_mem_w_data  : store data (Rc), 0 unless storing
//   d_mem_r_data  : load data (combinational)
//   d_mem_we      : store strobe, memory writes at next rising edge
//   d_mem_oe      : load strobe during LD/LDR
module beta_core
    import beta_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] i_mem_r_addr,
    input  logic [31:0] i_mem_r_data,
    output logic [31:0] d_mem_w_addr,
    output logic [31:0] d_mem_w_data,
    input  logic [31:0] d_mem_r_data,
    output logic        d_mem_we,
    output logic        d_mem_oe
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q [0:31];   // entry 31 is never written and reads as 0

    logic [5:0]  opcode;
    logic [4:0]  rc, ra, rb, rb_sel;
    logic [31:0] sxt, ra_val, rb_val, alu_b, alu_res;
    logic [31:0] pc_inc, br_tgt;
    logic        is_alu;
    logic        wr_en;
    logic [31:0] wr_data;

    assign opcode = i_mem_r_data[31:26];
    assign rc     = i_mem_r_data[25:21];
    assign ra     = i_mem_r_data[20:16];
    assign rb     = i_mem_r_data[15:11];
    assign sxt    = {{16{i_mem_r_data[15]}}, i_mem_r_data[15:0]};

    // Second read port serves Rb for ALU ops and Rc for store data.
    assign rb_sel = (opcode == OPCODE_ST) ? rc : rb;
    assign ra_val = (ra == 5'd31) ? 32'd0 : rf_q[ra];
    assign rb_val = (rb_sel == 5'd31) ? 32'd0 : rf_q[rb_sel];

    assign pc_inc = pc_q + 32'd4;
    assign br_tgt = pc_inc + {sxt[29:0], 2'b00};

    // opcode[5] selects the OP/OPC groups; opcode[4] picks the literal operand.
    assign is_alu = opcode[5] && alu_fn_valid(opcode[3:0]);
    assign alu_b  = opcode[4] ? sxt : rb_val;

    beta_alu u_alu (
        .a_i      (ra_val),
        .b_i      (alu_b),
        .fn_i     (alu_fn_e'(opcode[3:0])),
        .result_o (alu_res)
    );

    assign i_mem_r_addr = rst ? RESET_PC : pc_q;

    always_comb begin
        pc_d         = pc_inc;
        wr_en        = 1'b0;
        wr_data      = alu_res;
        d_mem_w_addr = '0;
        d_mem_w_data = '0;
        d_mem_we     = 1'b0;
        d_mem_oe     = 1'b0;

        if (is_alu) begin
            wr_en = 1'b1;
        end else begin
            unique case (opcode)
                OPCODE_LD: begin
                    d_mem_w_addr = ra_val + sxt;
                    d_mem_oe     = 1'b1;
                    wr_en        = 1'b1;
                    wr_data      = d_mem_r_data;
                end
                OPCODE_ST: begin
                    d_mem_w_addr = ra_val + sxt;
                    d_mem_w_data = rb_val;
                    d_mem_we     = 1'b1;
                end
                OPCODE_LDR: begin
                    d_mem_w_addr = br_tgt;
                    d_mem_oe     = 1'b1;
                    wr_en        = 1'b1;
                    wr_data      = d_mem_r_data;
                end
                OPCODE_JMP: begin
                    wr_en   = 1'b1;
                    wr_data = pc_inc;
                    pc_d    = {ra_val[31:2], 2'b00};
                end
                OPCODE_BEQ, OPCODE_BNE: begin
                    wr_en   = 1'b1;
                    wr_data = pc_inc;
                    if ((ra_val == 32'd0) == (opcode == OPCODE_BEQ))
                        pc_d = br_tgt;
                end
                default: ;  // NOP
            endcase
        end

        // Reset aborts the instruction in flight: no strobes, no writeback.
        if (rst) begin
            pc_d         = RESET_PC;
            wr_en        = 1'b0;
            d_mem_w_addr = '0;
            d_mem_w_data = '0;
            d_mem_we     = 1'b0;
            d_mem_oe     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            pc_q <= {pc_d[31:2], 2'b00};
            if (wr_en && rc != 5'd31) rf_q[rc] <= wr_data;
        end
    end

endmodule

// File: tb/tb_beta_core.sv
module tb_beta_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_mem_r_addr, i_mem_r_data;
    logic [31:0] d_mem_w_addr, d_mem_w_data, d_mem_r_data;
    logic        d_mem_we, d_mem_oe;

    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:255];

    always #5 clk = ~clk;

    assign i_mem_r_data = imem[i_mem_r_addr[9:2]];
    assign d_mem_r_data = dmem[d_mem_w_addr[9:2]];

    beta_core #(.RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_mem_r_addr (i_mem_r_addr),
        .i_mem_r_data (i_mem_r_data),
        .d_mem_w_addr (d_mem_w_addr),
        .d_mem_w_data (d_mem_w_data),
        .d_mem_r_data (d_mem_r_data),
        .d_mem_we     (d_mem_we),
        .d_mem_oe     (d_mem_oe)
    );

    int checks   = 0;
    int failures = 0;
    int n_we, n_oe;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ISA-level reference model
    logic [31:0] m_pc;
    logic [31:0] m_rf  [0:31];
    logic [31:0] m_mem [0:255];

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rc,
                                        input logic [4:0] ra, input logic [15:0] lit);
        return {op, rc, ra, lit};
    endfunction

    function automatic logic [31:0] encr(input logic [5:0] op, input logic [4:0] rc,
                                         input logic [4:0] ra, input logic [4:0] rb);
        return {op, rc, ra, rb, 11'b0};
    endfunction

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    endtask

    task automatic model_step(output logic [31:0] ea, output logic [31:0] ewd,
                              output logic ewe, output logic eoe);
        logic [31:0] ins, a, b, y, sx, val, nxt;
        logic [5:0]  op;
        logic [4:0]  rc, ra, rb;
        logic        wr;
        ins = imem[m_pc[9:2]];
        op = ins[31:26]; rc = ins[25:21]; ra = ins[20:16]; rb = ins[15:11];
        sx = {{16{ins[15]}}, ins[15:0]};
        a = m_rf[ra]; b = m_rf[rb];
        ea = 0; ewd = 0; ewe = 0; eoe = 0; wr = 0; val = 0; nxt = m_pc + 4;
        if (op >= 6'h20) begin
            y  = (op >= 6'h30) ? sx : b;
            wr = 1;
            case (op[3:0])
                4'h0: val = a + y;
                4'h1: val = a - y;
                4'h2: val = a * y;
                4'h4: val = {31'b0, a == y};
                4'h5: val = {31'b0, $signed(a) <  $signed(y)};
                4'h6: val = {31'b0, $signed(a) <= $signed(y)};
                4'h8: val = a & y;
                4'h9: val = a | y;
                4'hA: val = a ^ y;
                4'hB: val = ~(a ^ y);
                4'hC: val = a << y[4:0];
                4'hD: val = a >> y[4:0];
                4'hE: val = $unsigned($signed(a) >>> y[4:0]);
                default: wr = 0;
            endcase
        end else begin
            case (op)
                6'h18: begin ea = a + sx; eoe = 1; val = m_mem[ea[9:2]]; wr = 1; end
                6'h19: begin ea = a + sx; ewd = m_rf[rc]; ewe = 1; end
                6'h1F: begin ea = m_pc + 4 + (sx << 2); eoe = 1; val = m_mem[ea[9:2]]; wr = 1; end
                6'h1B: begin val = m_pc + 4; wr = 1; nxt = a & ~32'd3; end
                6'h1C, 6'h1D: begin
                    val = m_pc + 4; wr = 1;
                    if ((a == 0) == (op == 6'h1C)) nxt = m_pc + 4 + (sx << 2);
                end
                default: ;
            endcase
        end
        if (ewe) m_mem[ea[9:2]] = ewd;
        if (wr && rc != 5'd31) m_rf[rc] = val;
        m_pc = nxt;
    endtask

    task automatic clear_mems();
        for (int i = 0; i < 256; i++) begin imem[i] = 32'h0; dmem[i] = 32'h0; end
    endtask

    task automatic sync_mem();
        for (int i = 0; i < 256; i++) m_mem[i] = dmem[i];
    endtask

    // Leaves the bench at a negedge with rst just released.
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", i_mem_r_addr, 32'h0);
        chk("rst_we", {31'b0, d_mem_we}, 32'h0);
        chk("rst_oe", {31'b0, d_mem_oe}, 32'h0);
        rst = 1'b0;
        model_reset();
        sync_mem();
    endtask

    // Lock-step: compare DUT outputs against the model every cycle.
    task automatic run(input int n);
        logic [31:0] ea, ewd, pc_exp, wa, wd;
        logic        ewe, eoe, we;
        for (int c = 0; c < n; c++) begin
            #1;
            pc_exp = m_pc;
            model_step(ea, ewd, ewe, eoe);
            chk("pc",    i_mem_r_addr, pc_exp);
            chk("we",    {31'b0, d_mem_we}, {31'b0, ewe});
            chk("oe",    {31'b0, d_mem_oe}, {31'b0, eoe});
            chk("addr",  d_mem_w_addr, ea);
            chk("wdata", d_mem_w_data, ewd);
            if (d_mem_we) n_we++;
            if (d_mem_oe) n_oe++;
            we = d_mem_we; wa = d_mem_w_addr; wd = d_mem_w_data;
            @(posedge clk);
            if (we) dmem[wa[9:2]] = wd;
            @(negedge clk);
        end
    endtask

    task automatic load_sum();
        clear_mems();
        imem[0] = enc(6'h30, 0, 31, 16'd0);
        imem[1] = enc(6'h30, 1, 31, 16'd100);
        imem[2] = encr(6'h20, 0, 1, 0);
        imem[3] = enc(6'h31, 1, 1, 16'd1);
        imem[4] = enc(6'h1D, 31, 1, 16'hFFFD);
        imem[5] = enc(6'h1C, 31, 31, 16'hFFFF);
    endtask

    initial begin
        logic [31:0] r;
        int          k;
        logic [5:0]  op;

        // Sum loop 1..100
        load_sum();
        do_reset();
        run(320);
        #1;
        chk("sum_halt_pc", i_mem_r_addr, 32'h14);
        chk("sum_r0", dut.rf_q[0], 32'd5050);
        chk("sum_r1", dut.rf_q[1], 32'd0);

        // Reset in the middle of the loop, then rerun
        run(40);
        rst = 1'b1;
        #1;
        chk("midrst_we",   {31'b0, d_mem_we}, 32'h0);
        chk("midrst_addr", d_mem_w_addr, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_pc", i_mem_r_addr, 32'h0);
        chk("midrst_r0", dut.rf_q[0], 32'h0);
        chk("midrst_r1", dut.rf_q[1], 32'h0);
        rst = 1'b0;
        model_reset();
        sync_mem();
        run(320);
        chk("rerun_r0", dut.rf_q[0], 32'd5050);

        // OR then single store
        clear_mems();
        imem[0] = enc(6'h30, 0, 0, 16'd1);
        imem[1] = enc(6'h30, 1, 1, 16'd2);
        imem[2] = encr(6'h29, 2, 1, 0);
        imem[3] = enc(6'h19, 2, 31, 16'h0100);
        imem[4] = enc(6'h1C, 31, 31, 16'hFFFF);
        do_reset();
        n_we = 0; n_oe = 0;
        run(20);
        chk("or_st_mem", dmem[64], 32'd3);
        chk("or_st_wecnt", n_we, 1);

        // Store / load / store round trip
        clear_mems();
        imem[0] = enc(6'h30, 5, 31, 16'hDEAE);
        imem[1] = enc(6'h3C, 5, 5, 16'd16);
        imem[2] = enc(6'h30, 5, 5, 16'hBEEF);
        imem[3] = enc(6'h19, 5, 31, 16'h0040);
        imem[4] = enc(6'h18, 3, 31, 16'h0040);
        imem[5] = enc(6'h19, 3, 31, 16'h0044);
        imem[6] = enc(6'h1C, 31, 31, 16'hFFFF);
        do_reset();
        n_we = 0; n_oe = 0;
        run(15);
        chk("ldst_m40", dmem[16], 32'hDEADBEEF);
        chk("ldst_m44", dmem[17], 32'hDEADBEEF);
        chk("ldst_oecnt", n_oe, 1);

        // R31 write ignored; JMP to unaligned register value
        clear_mems();
        dmem[4] = 32'h5555_5555;
        imem[0] = enc(6'h30, 4, 31, 16'h0023);
        imem[1] = enc(6'h30, 31, 31, 16'd7);
        imem[2] = enc(6'h1B, 6, 4, 16'h0);
        imem[8] = enc(6'h19, 31, 31, 16'h0010);
        imem[9] = enc(6'h19, 6, 31, 16'h0014);
        imem[10] = enc(6'h1C, 31, 31, 16'hFFFF);
        do_reset();
        run(3);
        #1;
        chk("jmp_pc", i_mem_r_addr, 32'h20);
        run(6);
        chk("r31_mem", dmem[4], 32'h0);
        chk("jmp_link", dmem[5], 32'hC);

        // NOP words and shifts
        clear_mems();
        dmem[10] = 32'h1234_5678;
        imem[0] = 32'h0;
        imem[1] = enc(6'h31, 1, 31, 16'd1);
        imem[2] = encr(6'h23, 5, 1, 1);
        imem[3] = enc(6'h33, 5, 1, 16'd3);
        imem[4] = enc(6'h3E, 2, 1, 16'd4);
        imem[5] = enc(6'h3D, 3, 1, 16'd28);
        imem[6] = enc(6'h19, 2, 31, 16'h0020);
        imem[7] = enc(6'h19, 3, 31, 16'h0024);
        imem[8] = enc(6'h19, 5, 31, 16'h0028);
        imem[9] = enc(6'h1C, 31, 31, 16'hFFFF);
        do_reset();
        run(14);
        chk("srac", dmem[8], 32'hFFFF_FFFF);
        chk("shrc", dmem[9], 32'h0000_000F);
        chk("div_nop", dmem[10], 32'h0);

        // Random programs in lock-step with the model
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 256; i++) begin
                r = $urandom();
                dmem[i] = r;
                r = $urandom();
                k = $urandom_range(0, 9);
                case (k)
                    0, 1, 2, 3: op = 6'h20 + 6'($urandom_range(0, 31));
                    4: op = 6'h18;
                    5: op = 6'h19;
                    6: op = 6'h1F;
                    7: op = ($urandom_range(0, 1) == 0) ? 6'h1C : 6'h1D;
                    8: op = 6'h1B;
                    default: op = 6'($urandom_range(0, 63));
                endcase
                imem[i] = {op, r[25:0]};
            end
            do_reset();
            run(200);
            for (int i = 0; i < 256; i += 16) chk("rnd_mem", dmem[i], m_mem[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
